// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/response sequencer, shared adder and intermediate registers for a multdiv unit
module multdiv_issue_ctrl #(
    parameter logic DataIndTiming = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,

    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        data_ind_timing_o,
    output logic        md_ready_id_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,

    input  logic [32:0] alu_operand_a_i,
    input  logic [32:0] alu_operand_b_i,
    output logic [33:0] alu_adder_ext_o,
    output logic [31:0] alu_adder_o,
    output logic        equal_to_zero_o,

    input  logic [33:0] imd_val_d_i [2],
    input  logic [1:0]  imd_val_we_i,
    output logic [33:0] imd_val_q_o [2]
);

    typedef enum logic [1:0] {
        MD_MULL = 2'd0,
        MD_MULH = 2'd1,
        MD_DIV  = 2'd2,
        MD_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    md_op_e      op_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] a_q, b_q, result_q;
    logic [33:0] imd_q [2];
    logic        accept;
    logic        is_div;

    assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    // DIV and REM share op[1]; MULL and MULH have it clear
    assign is_div      = (op_q == MD_DIV) || (op_q == MD_REM);

    always_comb begin
        state_d       = state_q;
        mult_en_o     = 1'b0;
        div_en_o      = 1'b0;
        md_ready_id_o = 1'b0;
        rsp_valid_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                md_ready_id_o = 1'b1;
                mult_en_o     = !is_div;
                div_en_o      = is_div;
                if (md_valid_i) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = req_valid_i ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mult_sel_o = mult_en_o;
    assign div_sel_o  = div_en_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            op_q          <= MD_MULL;
            signed_mode_q <= 2'b00;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            result_q      <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q          <= md_op_e'(req_op_i);
                signed_mode_q <= req_signed_mode_i;
                a_q           <= req_a_i;
                b_q           <= req_b_i;
            end
            if ((state_q == BUSY) && md_valid_i) result_q <= md_result_i;
        end
    end

    // Intermediate registers belong to the multdiv datapath, not the sequencer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imd_q[0] <= 34'd0;
            imd_q[1] <= 34'd0;
        end else begin
            if (imd_val_we_i[0]) imd_q[0] <= imd_val_d_i[0];
            if (imd_val_we_i[1]) imd_q[1] <= imd_val_d_i[1];
        end
    end

    assign imd_val_q_o[0] = imd_q[0];
    assign imd_val_q_o[1] = imd_q[1];

    assign operator_o        = op_q;
    assign signed_mode_o     = signed_mode_q;
    assign op_a_o            = a_q;
    assign op_b_o            = b_q;
    assign rsp_result_o      = result_q;
    assign data_ind_timing_o = DataIndTiming;

    // Bit 0 is the carry-in slot, so the 32-bit sum sits in [32:1]
    assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
    assign alu_adder_o     = alu_adder_ext_o[32:1];
    assign equal_to_zero_o = (alu_adder_o == 32'd0);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - directed self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [1:0]  req_op_i, req_signed_mode_i;
    logic [31:0] req_a_i, req_b_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    logic [1:0]  operator_o, signed_mode_o;
    logic [31:0] op_a_o, op_b_o;
    logic        data_ind_timing_o, md_ready_id_o, md_valid_i;
    logic [31:0] md_result_i;
    logic [32:0] alu_operand_a_i, alu_operand_b_i;
    logic [33:0] alu_adder_ext_o;
    logic [31:0] alu_adder_o;
    logic        equal_to_zero_o;
    logic [33:0] imd_val_d_i [2];
    logic [1:0]  imd_val_we_i;
    logic [33:0] imd_val_q_o [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    multdiv_issue_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_signed_mode_i(req_signed_mode_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .operator_o(operator_o), .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .data_ind_timing_o(data_ind_timing_o), .md_ready_id_o(md_ready_id_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i),
        .alu_operand_a_i(alu_operand_a_i), .alu_operand_b_i(alu_operand_b_i),
        .alu_adder_ext_o(alu_adder_ext_o), .alu_adder_o(alu_adder_o), .equal_to_zero_o(equal_to_zero_o),
        .imd_val_d_i(imd_val_d_i), .imd_val_we_i(imd_val_we_i), .imd_val_q_o(imd_val_q_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b);
        req_valid_i = 1'b1; req_op_i = op; req_signed_mode_i = mode;
        req_a_i = a; req_b_i = b;
        #1 chk("issue_req_ready", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic busy_chk(input logic [1:0] op, input logic [1:0] mode,
                            input logic [31:0] a, input logic [31:0] b);
        chk("busy_mult_en", mult_en_o, !op[1]);
        chk("busy_mult_sel", mult_sel_o, !op[1]);
        chk("busy_div_en", div_en_o, op[1]);
        chk("busy_div_sel", div_sel_o, op[1]);
        chk("busy_md_ready", md_ready_id_o, 1);
        chk("busy_rsp_valid", rsp_valid_o, 0);
        chk("busy_operator", operator_o, op);
        chk("busy_signed_mode", signed_mode_o, mode);
        chk("busy_op_a", op_a_o, a);
        chk("busy_op_b", op_b_o, b);
    endtask

    task automatic md_return(input logic [31:0] res);
        md_valid_i = 1'b1; md_result_i = res;
        step();
        md_valid_i = 1'b0; md_result_i = 32'h0;
        chk("resp_valid", rsp_valid_o, 1);
        chk("resp_result", rsp_result_o, res);
        chk("resp_md_ready", md_ready_id_o, 0);
        chk("resp_en", {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, 0);
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        #1 chk("hs_req_ready", req_ready_o, 1);
        step();
        rsp_ready_i = 1'b0;
        chk("hs_idle_rsp_valid", rsp_valid_o, 0);
        chk("hs_idle_req_ready", req_ready_o, 1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        issue(op, mode, a, b);
        busy_chk(op, mode, a, b);
        md_return(res);
        handshake();
    endtask

    initial begin
        rst_ni = 1'b0; req_valid_i = 0; req_op_i = 0; req_signed_mode_i = 0;
        req_a_i = 0; req_b_i = 0; rsp_ready_i = 0; md_valid_i = 0; md_result_i = 0;
        alu_operand_a_i = 0; alu_operand_b_i = 0; imd_val_we_i = 0;
        imd_val_d_i[0] = 0; imd_val_d_i[1] = 0;
        #3;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_en_sel", {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, 0);
        chk("rst_md_ready", md_ready_id_o, 0);
        chk("rst_regs", {op_a_o, op_b_o}, 0);
        chk("rst_result", {operator_o, signed_mode_o, rsp_result_o}, 0);
        chk("rst_imd", {imd_val_q_o[0][29:0], imd_val_q_o[1][33:0]}, 0);
        chk("data_ind_timing", data_ind_timing_o, 0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // MULL 7*6, busy for two cycles, then response held with rsp_ready low
        issue(2'd0, 2'b00, 32'd7, 32'd6);
        busy_chk(2'd0, 2'b00, 32'd7, 32'd6);
        step();
        busy_chk(2'd0, 2'b00, 32'd7, 32'd6);
        md_return(32'h0000_002A);
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1; req_op_i = 2'd2; req_a_i = 32'd99; req_b_i = 32'd11;
            md_valid_i = (i == 0); md_result_i = 32'hDEAD_BEEF;
            #1 chk("hold_req_ready", req_ready_o, 0);
            step();
            md_valid_i = 1'b0;
            chk("hold_rsp_valid", rsp_valid_o, 1);
            chk("hold_rsp_result", rsp_result_o, 32'h0000_002A);
            chk("hold_op_a", op_a_o, 32'd7);
            chk("hold_operator", operator_o, 2'd0);
        end
        req_valid_i = 1'b0;
        handshake();

        run_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(2'd2, 2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(2'd3, 2'b11, 32'd7, 32'd0, 32'h0000_0007);

        // back-to-back: REM accepted in the MULH response cycle
        issue(2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000);
        busy_chk(2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000);
        md_return(32'h4000_0000);
        rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_op_i = 2'd3;
        req_signed_mode_i = 2'b00; req_a_i = 32'd17; req_b_i = 32'd5;
        #1 chk("b2b_req_ready", req_ready_o, 1);
        chk("b2b_first_result", rsp_result_o, 32'h4000_0000);
        step();
        req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        busy_chk(2'd3, 2'b00, 32'd17, 32'd5);
        md_return(32'h0000_0002);
        handshake();

        alu_operand_a_i = 33'h1; alu_operand_b_i = {~32'h0, 1'b1};
        #1;
        chk("add_wrap_ext", alu_adder_ext_o, 34'h2_0000_0000);
        chk("add_wrap_sum", alu_adder_o, 0);
        chk("add_wrap_zero", equal_to_zero_o, 1);
        alu_operand_a_i = 33'd5; alu_operand_b_i = 33'd3;
        #1;
        chk("add_small_ext", alu_adder_ext_o, 34'd8);
        chk("add_small_sum", alu_adder_o, 32'd4);
        chk("add_small_zero", equal_to_zero_o, 0);

        imd_val_d_i[0] = 34'h3_1234_5678; imd_val_d_i[1] = 34'h2_ABCD_EF01; imd_val_we_i = 2'b01;
        step();
        imd_val_we_i = 2'b00;
        chk("imd0_written", imd_val_q_o[0], 34'h3_1234_5678);
        chk("imd1_untouched", imd_val_q_o[1], 34'h0);
        imd_val_we_i = 2'b10;
        step();
        imd_val_we_i = 2'b00;
        chk("imd1_written", imd_val_q_o[1], 34'h2_ABCD_EF01);

        // async reset in the middle of a DIV
        issue(2'd2, 2'b00, 32'd100, 32'd9);
        busy_chk(2'd2, 2'b00, 32'd100, 32'd9);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready_o, 1);
        chk("mid_rst_md_ready", md_ready_id_o, 0);
        chk("mid_rst_en_sel", {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, 0);
        chk("mid_rst_ops", {op_a_o, op_b_o}, 0);
        chk("mid_rst_imd", imd_val_q_o[0], 0);
        step();
        rst_ni = 1'b1;
        md_valid_i = 1'b1; md_result_i = 32'h0000_000B;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid_o, 0);
        end
        md_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
